// File: rtl/vga_line_fetch.sv
// Framebuffer read DMA: AXI4 INCR read bursts into a 64-bit FIFO, unpacked to a 32-bit pixel stream.
// Optional underflow statistics counter enabled by defining VGA_LINE_FETCH_STAT_EN.
module vga_line_fetch #(
    parameter int H_PIX      = 640,
    parameter int V_LINES    = 480,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_fb_base,
    input  logic        io_frame_start,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [63:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,
    output logic        io_pix_valid,
    input  logic        io_pix_ready,
    output logic [31:0] io_pix_data,
    output logic        io_err
`ifdef VGA_LINE_FETCH_STAT_EN
    ,
    output logic [15:0] io_underflow_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for frame start, remaining words and FIFO space for a whole burst
    // ADDR  | presenting AR for the burst at cur_addr
    // DATA  | accepting R beats into the FIFO until rlast
    // DRAIN | frame restarted mid-burst; swallowing beats until rlast, then reload
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TOTAL_WORDS = 32'(H_PIX * V_LINES / 2);
    localparam logic [31:0] BURST_W     = 32'(BURST_LEN);
    localparam logic [31:0] ADDR_STEP   = 32'(BURST_LEN * 8);
    localparam logic [AW:0] DEPTH_C     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] BURST_C     = (AW+1)'(BURST_LEN);

    state_t       state;
    logic [31:0]  cur_addr;
    logic [31:0]  words_left;
    logic [31:0]  pend_base;
    logic         arvalid_q;
    logic [31:0]  araddr_q;
    logic         rready_q;
    logic         err_q;

    logic [63:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;
    logic         half;

    logic         beat;
    logic         push;
    logic         pop;
    logic         pix_fire;
    logic         restart;
    logic [31:0]  restart_base;
    logic [AW:0]  free_space;
    logic [63:0]  head;
    logic         unused_rid;

    assign unused_rid = ^io_master_rid;

    assign beat       = io_master_rvalid && rready_q;
    assign push       = (state == DATA) && beat && !io_frame_start;
    assign io_pix_valid = (count != '0);
    assign pix_fire   = io_pix_valid && io_pix_ready;
    assign pop        = pix_fire && half;
    assign free_space = DEPTH_C - count;
    assign head       = mem[rd_ptr];
    assign io_pix_data = io_pix_valid ? (half ? head[63:32] : head[31:0]) : 32'h0;

    // A restart reloads the frame pointers and flushes the FIFO; it never
    // happens while a burst is still outstanding on the R channel.
    always_comb begin
        restart      = 1'b0;
        restart_base = io_fb_base;
        case (state)
            IDLE:  restart = io_frame_start;
            ADDR:  restart = io_frame_start && !io_master_arready;
            DATA:  restart = io_frame_start && beat && io_master_rlast;
            DRAIN: begin
                restart      = beat && io_master_rlast;
                restart_base = io_frame_start ? io_fb_base : pend_base;
            end
            default: restart = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            words_left <= '0;
            pend_base  <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (beat && io_master_rresp != 2'b00)
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (!io_frame_start && words_left != '0 && free_space >= BURST_C) begin
                        state     <= ADDR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= cur_addr;
                    end
                end
                ADDR: begin
                    if (io_master_arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        cur_addr   <= cur_addr + ADDR_STEP;
                        words_left <= words_left - BURST_W;
                        if (io_frame_start) begin
                            pend_base <= io_fb_base;
                            state     <= DRAIN;
                        end else begin
                            state <= DATA;
                        end
                    end else if (io_frame_start) begin
                        arvalid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DATA: begin
                    if (beat && io_master_rlast) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end else if (io_frame_start) begin
                        pend_base <= io_fb_base;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (io_frame_start)
                        pend_base <= io_fb_base;
                    if (beat && io_master_rlast) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (restart) begin
                cur_addr   <= restart_base;
                words_left <= TOTAL_WORDS;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            half   <= 1'b0;
        end else if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            half   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (pix_fire)
                half <= ~half;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= io_master_rdata;
    end

`ifdef VGA_LINE_FETCH_STAT_EN
    logic [15:0] underflow_q;
    logic        fetch_active;

    assign fetch_active = (words_left != '0) || (count != '0) || (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            underflow_q <= '0;
        else if (io_pix_ready && !io_pix_valid && fetch_active && underflow_q != 16'hFFFF)
            underflow_q <= underflow_q + 16'd1;
    end

    assign io_underflow_cnt = underflow_q;
`endif

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = araddr_q;
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'(BURST_LEN - 1);
    assign io_master_arsize  = 3'd3;
    assign io_master_arburst = 2'd1;
    assign io_master_rready  = rready_q;
    assign io_err            = err_q;

endmodule
